// File: rtl/alu_arbiter_pkg.sv
// Shared definitions for the two-requester ALU arbiter: MIPS funct codes,
// arbiter state encoding and the funct-valid check.
`ifndef ALU_ARBITER_PKG_SV
`define ALU_ARBITER_PKG_SV

`define ALU_ARB_FUNCT_VALID(f) (alu_arbiter_pkg::funct_is_valid(f))

package alu_arbiter_pkg;

  localparam logic [5:0] FUNCT_ADD  = 6'h20;
  localparam logic [5:0] FUNCT_SUB  = 6'h22;
  localparam logic [5:0] FUNCT_AND  = 6'h24;
  localparam logic [5:0] FUNCT_OR   = 6'h25;
  localparam logic [5:0] FUNCT_XOR  = 6'h26;
  localparam logic [5:0] FUNCT_NOR  = 6'h27;
  localparam logic [5:0] FUNCT_SLT  = 6'h2A;
  localparam logic [5:0] FUNCT_NOOP = 6'h2C;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    RESP = 2'd2
  } arb_state_t;

  function automatic logic funct_is_valid(input logic [5:0] f);
    case (f)
      FUNCT_ADD, FUNCT_SUB, FUNCT_AND, FUNCT_OR,
      FUNCT_XOR, FUNCT_NOR, FUNCT_SLT, FUNCT_NOOP: return 1'b1;
      default:                                     return 1'b0;
    endcase
  endfunction

endpackage

`endif

// File: rtl/alu_arbiter_picker.sv
// Combinational 2-way round-robin picker: a lone requester wins outright,
// a tie goes to the requester that was not granted last.
module alu_rr_picker (
  input  logic [1:0] req_valid,
  input  logic       last_grant,
  output logic [1:0] grant
);

  always_comb begin
    grant = req_valid;
    if (req_valid == 2'b11) begin
      grant = last_grant ? 2'b01 : 2'b10;
    end
  end

endmodule

// File: rtl/alu_arbiter.sv
// Shares one MIPS ALU between two valid/ready requesters with round-robin
// arbitration. Define ALU_ARB_FLAGS_EN to add rsp_zero/rsp_ovf/rsp_cout.
module alu_arbiter
  import alu_arbiter_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int CNT_W  = 16
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [1:0]          req_valid,
  output logic [1:0]          req_ready,
  input  logic [11:0]         req_funct,
  input  logic [2*DATA_W-1:0] req_a,
  input  logic [2*DATA_W-1:0] req_b,
  input  logic [1:0]          req_cin,
  output logic [5:0]          alu_funct,
  output logic [DATA_W-1:0]   alu_a,
  output logic [DATA_W-1:0]   alu_b,
  output logic                alu_cin,
  input  logic [DATA_W-1:0]   alu_res,
  input  logic                alu_zero,
  input  logic                alu_ovf,
  input  logic                alu_cout,
  output logic                rsp_valid,
  input  logic                rsp_ready,
  output logic                rsp_id,
  output logic [DATA_W-1:0]   rsp_data,
  output logic                rsp_err,
`ifdef ALU_ARB_FLAGS_EN
  output logic                rsp_zero,
  output logic                rsp_ovf,
  output logic                rsp_cout,
`endif
  output logic [CNT_W-1:0]    op_count
);

  arb_state_t          state, next_state;
  logic                last_grant;
  logic [1:0]          grant;
  logic                grant_id;
  logic [5:0]          sel_funct;
  logic [5:0]          op_funct;
  logic [DATA_W-1:0]   op_a, op_b;
  logic                op_cin;

  alu_rr_picker u_picker (
    .req_valid  (req_valid),
    .last_grant (last_grant),
    .grant      (grant)
  );

  assign grant_id  = grant[1];
  assign sel_funct = grant_id ? req_funct[11:6] : req_funct[5:0];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= next_state;
  end

  always_comb begin
    next_state = state;
    case (state)
      IDLE:    if (|grant) next_state = `ALU_ARB_FUNCT_VALID(sel_funct) ? EXEC : RESP;
      EXEC:    next_state = RESP;
      RESP:    if (rsp_ready) next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  // The ALU only ever sees a real funct during the single EXEC cycle.
  always_comb begin
    req_ready = (state == IDLE) ? grant : 2'b00;
    rsp_valid = (state == RESP);
    alu_funct = (state == EXEC) ? op_funct : FUNCT_NOOP;
    alu_a     = op_a;
    alu_b     = op_b;
    alu_cin   = op_cin;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      last_grant <= 1'b1;
      op_funct   <= '0;
      op_a       <= '0;
      op_b       <= '0;
      op_cin     <= 1'b0;
      rsp_id     <= 1'b0;
      rsp_data   <= '0;
      rsp_err    <= 1'b0;
`ifdef ALU_ARB_FLAGS_EN
      rsp_zero   <= 1'b0;
      rsp_ovf    <= 1'b0;
      rsp_cout   <= 1'b0;
`endif
      op_count   <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (|grant) begin
            op_funct   <= sel_funct;
            op_a       <= grant_id ? req_a[2*DATA_W-1:DATA_W] : req_a[DATA_W-1:0];
            op_b       <= grant_id ? req_b[2*DATA_W-1:DATA_W] : req_b[DATA_W-1:0];
            op_cin     <= req_cin[grant_id];
            last_grant <= grant_id;
            rsp_id     <= grant_id;
            // Unsupported funct skips EXEC and answers with an error.
            if (!`ALU_ARB_FUNCT_VALID(sel_funct)) begin
              rsp_err  <= 1'b1;
              rsp_data <= '0;
`ifdef ALU_ARB_FLAGS_EN
              rsp_zero <= 1'b0;
              rsp_ovf  <= 1'b0;
              rsp_cout <= 1'b0;
`endif
            end
          end
        end
        EXEC: begin
          // NOOP leaves the ALU output floating, so never capture it.
          rsp_err  <= 1'b0;
          rsp_data <= (op_funct == FUNCT_NOOP) ? '0 : alu_res;
`ifdef ALU_ARB_FLAGS_EN
          rsp_zero <= (op_funct == FUNCT_NOOP) ? 1'b0 : alu_zero;
          rsp_ovf  <= (op_funct == FUNCT_NOOP) ? 1'b0 : alu_ovf;
          rsp_cout <= (op_funct == FUNCT_NOOP) ? 1'b0 : alu_cout;
`endif
        end
        RESP: begin
          if (rsp_ready && (op_count != {CNT_W{1'b1}})) begin
            op_count <= op_count + CNT_W'(1);
          end
        end
        default: ;
      endcase
    end
  end

`ifndef ALU_ARB_FLAGS_EN
  logic unused_flags;
  assign unused_flags = alu_zero ^ alu_ovf ^ alu_cout;
`endif

endmodule

// File: tb/tb_alu_arbiter.sv
// Directed self-checking bench for alu_arbiter with a behavioural MIPS ALU
// stand-in; flag and saturation checks run only when ALU_ARB_FLAGS_EN is defined.
module tb_alu_arbiter;

  logic        clk;
  logic        rst_n;
  logic [1:0]  req_valid;
  logic [1:0]  req_ready;
  logic [11:0] req_funct;
  logic [63:0] req_a;
  logic [63:0] req_b;
  logic [1:0]  req_cin;
  logic [5:0]  alu_funct;
  logic [31:0] alu_a;
  logic [31:0] alu_b;
  logic        alu_cin;
  logic [31:0] alu_res;
  logic        alu_zero;
  logic        alu_ovf;
  logic        alu_cout;
  logic        rsp_valid;
  logic        rsp_ready;
  logic        rsp_id;
  logic [31:0] rsp_data;
  logic        rsp_err;
`ifdef ALU_ARB_FLAGS_EN
  logic        rsp_zero;
  logic        rsp_ovf;
  logic        rsp_cout;
`endif
  logic [15:0] op_count;

  int n_checks = 0;
  int n_fail   = 0;

  alu_arbiter #(.DATA_W(32), .CNT_W(16)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_funct (req_funct),
    .req_a     (req_a),
    .req_b     (req_b),
    .req_cin   (req_cin),
    .alu_funct (alu_funct),
    .alu_a     (alu_a),
    .alu_b     (alu_b),
    .alu_cin   (alu_cin),
    .alu_res   (alu_res),
    .alu_zero  (alu_zero),
    .alu_ovf   (alu_ovf),
    .alu_cout  (alu_cout),
    .rsp_valid (rsp_valid),
    .rsp_ready (rsp_ready),
    .rsp_id    (rsp_id),
    .rsp_data  (rsp_data),
    .rsp_err   (rsp_err),
`ifdef ALU_ARB_FLAGS_EN
    .rsp_zero  (rsp_zero),
    .rsp_ovf   (rsp_ovf),
    .rsp_cout  (rsp_cout),
`endif
    .op_count  (op_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Stand-in ALU; NOOP drives garbage so a missing force-to-zero shows up.
  always_comb begin
    logic [32:0] sum;
    sum      = 33'd0;
    alu_res  = 32'hDEADBEEF;
    alu_cout = 1'b0;
    alu_ovf  = 1'b0;
    case (alu_funct)
      6'h20: begin
        sum      = {1'b0, alu_a} + {1'b0, alu_b} + {32'd0, alu_cin};
        alu_res  = sum[31:0];
        alu_cout = sum[32];
        alu_ovf  = (alu_a[31] == alu_b[31]) && (sum[31] != alu_a[31]);
      end
      6'h22: begin
        sum      = {1'b0, alu_a} + {1'b0, ~alu_b} + 33'd1;
        alu_res  = sum[31:0];
        alu_cout = sum[32];
        alu_ovf  = (alu_a[31] != alu_b[31]) && (sum[31] != alu_a[31]);
      end
      6'h24: alu_res = alu_a & alu_b;
      6'h25: alu_res = alu_a | alu_b;
      6'h26: alu_res = alu_a ^ alu_b;
      6'h27: alu_res = ~(alu_a | alu_b);
      6'h2A: alu_res = {31'd0, ($signed(alu_a) < $signed(alu_b))};
      default: ;
    endcase
    alu_zero = (alu_funct == 6'h2C) ? 1'b1 : (alu_res == 32'd0);
  end

  task automatic do_reset();
    rst_n     = 1'b0;
    req_valid = 2'b00;
    req_funct = 12'h0;
    req_a     = 64'h0;
    req_b     = 64'h0;
    req_cin   = 2'b00;
    rsp_ready = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    do_reset();
    #1;
    n_checks++;
    if (rsp_valid !== 1'b0) begin n_fail++; $display("[TB] FAIL reset_rsp_valid: got %b want 0", rsp_valid); end
    n_checks++;
    if (op_count !== 16'h0) begin n_fail++; $display("[TB] FAIL reset_op_count: got %h want 0000", op_count); end
    n_checks++;
    if (alu_funct !== 6'h2C) begin n_fail++; $display("[TB] FAIL reset_alu_funct: got %h want 2c", alu_funct); end
    n_checks++;
    if ({rsp_id, rsp_err, rsp_data} !== 34'h0) begin n_fail++; $display("[TB] FAIL reset_rsp_fields: id %b err %b data %h want 0", rsp_id, rsp_err, rsp_data); end
  endtask

  task automatic test_basic_add();
    @(negedge clk);
    req_funct[5:0] = 6'h20; req_a[31:0] = 32'd5; req_b[31:0] = 32'd7; req_cin[0] = 1'b0;
    req_valid = 2'b01;
    #1;
    n_checks++;
    if (req_ready !== 2'b01) begin n_fail++; $display("[TB] FAIL basic_ready: got %b want 01", req_ready); end
    @(negedge clk);
    req_valid = 2'b00;
    #1;
    n_checks++;
    if ({rsp_valid, req_ready} !== 3'b000) begin n_fail++; $display("[TB] FAIL basic_exec_idle_outs: valid %b ready %b want 0/00", rsp_valid, req_ready); end
    n_checks++;
    if ({alu_funct, alu_a, alu_b} !== {6'h20, 32'd5, 32'd7}) begin n_fail++; $display("[TB] FAIL basic_alu_drive: funct %h a %h b %h want 20/5/7", alu_funct, alu_a, alu_b); end
    @(negedge clk);
    #1;
    n_checks++;
    if ({rsp_valid, rsp_id, rsp_err, rsp_data} !== {1'b1, 1'b0, 1'b0, 32'd12}) begin n_fail++; $display("[TB] FAIL basic_rsp: valid %b id %b err %b data %h want 1/0/0/0000000c", rsp_valid, rsp_id, rsp_err, rsp_data); end
    rsp_ready = 1'b1;
    @(negedge clk);
    rsp_ready = 1'b0;
    #1;
    n_checks++;
    if ({rsp_valid, op_count} !== {1'b0, 16'd1}) begin n_fail++; $display("[TB] FAIL basic_count: valid %b count %h want 0/0001", rsp_valid, op_count); end
  endtask

  task automatic test_noop();
    @(negedge clk);
    req_funct[11:6] = 6'h2C; req_a[63:32] = 32'd9; req_b[63:32] = 32'd9;
    req_valid = 2'b10;
    @(negedge clk);
    req_valid = 2'b00;
    @(negedge clk);
    #1;
    n_checks++;
    if ({rsp_valid, rsp_id, rsp_err, rsp_data} !== {1'b1, 1'b1, 1'b0, 32'd0}) begin n_fail++; $display("[TB] FAIL noop_rsp: valid %b id %b err %b data %h want 1/1/0/00000000", rsp_valid, rsp_id, rsp_err, rsp_data); end
    rsp_ready = 1'b1;
    @(negedge clk);
    rsp_ready = 1'b0;
  endtask

  task automatic test_back_to_back();
    logic [32:0] got [3];
    logic [32:0] want [3];
    int k;
    want[0] = {1'b0, 32'd7};
    want[1] = {1'b1, 32'd1};
    want[2] = {1'b0, 32'd7};
    k = 0;
    do_reset();
    req_funct = {6'h2A, 6'h22};
    req_a     = {32'd2, 32'd10};
    req_b     = {32'd9, 32'd3};
    req_valid = 2'b11;
    rsp_ready = 1'b1;
    for (int c = 0; c < 30 && k < 3; c++) begin
      @(negedge clk);
      #1;
      if (rsp_valid) begin
        got[k] = {rsp_id, rsp_data};
        k++;
      end
    end
    req_valid = 2'b00;
    @(negedge clk);
    rsp_ready = 1'b0;
    #1;
    n_checks++;
    if (k !== 3) begin n_fail++; $display("[TB] FAIL b2b_rsp_count: got %0d responses want 3", k); end
    for (int i = 0; i < k; i++) begin
      n_checks++;
      if (got[i] !== want[i]) begin n_fail++; $display("[TB] FAIL b2b_rsp%0d: id %b data %h want id %b data %h", i, got[i][32], got[i][31:0], want[i][32], want[i][31:0]); end
    end
    n_checks++;
    if (op_count !== 16'd3) begin n_fail++; $display("[TB] FAIL b2b_count: got %h want 0003", op_count); end
  endtask

  task automatic test_error();
    @(negedge clk);
    req_funct[11:6] = 6'h3F; req_a[63:32] = 32'd123; req_b[63:32] = 32'd4;
    req_valid = 2'b10;
    #1;
    n_checks++;
    if ({req_ready, alu_funct} !== {2'b10, 6'h2C}) begin n_fail++; $display("[TB] FAIL err_accept: ready %b alu_funct %h want 10/2c", req_ready, alu_funct); end
    @(negedge clk);
    req_valid = 2'b00;
    #1;
    n_checks++;
    if ({rsp_valid, rsp_id, rsp_err, rsp_data} !== {1'b1, 1'b1, 1'b1, 32'd0}) begin n_fail++; $display("[TB] FAIL err_rsp: valid %b id %b err %b data %h want 1/1/1/00000000", rsp_valid, rsp_id, rsp_err, rsp_data); end
    n_checks++;
    if (alu_funct !== 6'h2C) begin n_fail++; $display("[TB] FAIL err_alu_funct: got %h want 2c", alu_funct); end
    rsp_ready = 1'b1;
    @(negedge clk);
    rsp_ready = 1'b0;
    #1;
    n_checks++;
    if ({rsp_valid, op_count} !== {1'b0, 16'd4}) begin n_fail++; $display("[TB] FAIL err_count: valid %b count %h want 0/0004", rsp_valid, op_count); end
  endtask

  task automatic test_hold_resp();
    @(negedge clk);
    req_funct[5:0] = 6'h24; req_a[31:0] = 32'hF0; req_b[31:0] = 32'h3C;
    req_valid = 2'b01;
    @(negedge clk);
    req_funct[5:0] = 6'h25; req_a[31:0] = 32'd1; req_b[31:0] = 32'd2;
    @(negedge clk);
    #1;
    n_checks++;
    if ({rsp_valid, rsp_data} !== {1'b1, 32'h30}) begin n_fail++; $display("[TB] FAIL hold_first_rsp: valid %b data %h want 1/00000030", rsp_valid, rsp_data); end
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      #1;
      n_checks++;
      if ({rsp_valid, rsp_id, rsp_err, rsp_data, req_ready} !== {1'b1, 1'b0, 1'b0, 32'h30, 2'b00}) begin n_fail++; $display("[TB] FAIL hold_stable%0d: valid %b id %b err %b data %h ready %b want 1/0/0/00000030/00", i, rsp_valid, rsp_id, rsp_err, rsp_data, req_ready); end
    end
    rsp_ready = 1'b1;
    #1;
    n_checks++;
    if (req_ready !== 2'b00) begin n_fail++; $display("[TB] FAIL hold_handshake_ready: got %b want 00", req_ready); end
    @(negedge clk);
    rsp_ready = 1'b0;
    #1;
    n_checks++;
    if ({rsp_valid, req_ready} !== {1'b0, 2'b01}) begin n_fail++; $display("[TB] FAIL hold_reaccept: valid %b ready %b want 0/01", rsp_valid, req_ready); end
    @(negedge clk);
    req_valid = 2'b00;
    @(negedge clk);
    #1;
    n_checks++;
    if ({rsp_valid, rsp_data} !== {1'b1, 32'd3}) begin n_fail++; $display("[TB] FAIL hold_second_rsp: valid %b data %h want 1/00000003", rsp_valid, rsp_data); end
    rsp_ready = 1'b1;
    @(negedge clk);
    rsp_ready = 1'b0;
    #1;
    n_checks++;
    if (op_count !== 16'd6) begin n_fail++; $display("[TB] FAIL hold_count: got %h want 0006", op_count); end
  endtask

  task automatic test_reset_in_exec();
    @(negedge clk);
    req_funct[5:0] = 6'h20; req_a[31:0] = 32'd1; req_b[31:0] = 32'd1;
    req_valid = 2'b01;
    @(negedge clk);
    req_valid = 2'b00;
    #1;
    n_checks++;
    if (alu_funct !== 6'h20) begin n_fail++; $display("[TB] FAIL rexec_in_exec: alu_funct %h want 20", alu_funct); end
    #1;
    rst_n = 1'b0;
    #1;
    n_checks++;
    if ({rsp_valid, rsp_id, rsp_err, rsp_data, op_count} !== 51'h0) begin n_fail++; $display("[TB] FAIL rexec_rsp_cleared: valid %b id %b err %b data %h count %h want all 0", rsp_valid, rsp_id, rsp_err, rsp_data, op_count); end
    n_checks++;
    if ({alu_funct, alu_a, alu_b, req_ready} !== {6'h2C, 64'h0, 2'b00}) begin n_fail++; $display("[TB] FAIL rexec_alu_cleared: funct %h a %h b %h ready %b want 2c/0/0/00", alu_funct, alu_a, alu_b, req_ready); end
    @(negedge clk);
    rst_n = 1'b1;
    req_funct = {6'h24, 6'h26};
    req_a     = {32'hFF, 32'd6};
    req_b     = {32'hFF, 32'd3};
    req_valid = 2'b11;
    #1;
    n_checks++;
    if (req_ready !== 2'b01) begin n_fail++; $display("[TB] FAIL rexec_first_tie: ready %b want 01", req_ready); end
    @(negedge clk);
    req_valid = 2'b00;
    @(negedge clk);
    #1;
    n_checks++;
    if ({rsp_valid, rsp_id, rsp_err, rsp_data} !== {1'b1, 1'b0, 1'b0, 32'd5}) begin n_fail++; $display("[TB] FAIL rexec_next_rsp: valid %b id %b err %b data %h want 1/0/0/00000005", rsp_valid, rsp_id, rsp_err, rsp_data); end
    rsp_ready = 1'b1;
    @(negedge clk);
    rsp_ready = 1'b0;
    #1;
    n_checks++;
    if (op_count !== 16'd1) begin n_fail++; $display("[TB] FAIL rexec_count: got %h want 0001", op_count); end
  endtask

`ifdef ALU_ARB_FLAGS_EN
  task automatic test_flags_and_saturation();
    @(negedge clk);
    req_funct[5:0] = 6'h20; req_a[31:0] = 32'h7FFFFFFF; req_b[31:0] = 32'd1; req_cin[0] = 1'b0;
    req_valid = 2'b01;
    @(negedge clk);
    req_valid = 2'b00;
    @(negedge clk);
    #1;
    n_checks++;
    if ({rsp_data, rsp_ovf, rsp_zero, rsp_cout} !== {32'h80000000, 1'b1, 1'b0, 1'b0}) begin n_fail++; $display("[TB] FAIL flags_ovf: data %h ovf %b zero %b cout %b want 80000000/1/0/0", rsp_data, rsp_ovf, rsp_zero, rsp_cout); end
    rsp_ready = 1'b1;
    @(negedge clk);
    rsp_ready = 1'b0;
    force dut.op_count = 16'hFFFE;
    @(negedge clk);
    release dut.op_count;
    for (int i = 0; i < 2; i++) begin
      req_funct[5:0] = 6'h2C; req_valid = 2'b01;
      @(negedge clk);
      req_valid = 2'b00;
      @(negedge clk);
      @(negedge clk);
      #1;
      n_checks++;
      if ({rsp_zero, rsp_ovf, rsp_cout, rsp_data} !== 35'h0) begin n_fail++; $display("[TB] FAIL flags_noop%0d: zero %b ovf %b cout %b data %h want 0", i, rsp_zero, rsp_ovf, rsp_cout, rsp_data); end
      rsp_ready = 1'b1;
      @(negedge clk);
      rsp_ready = 1'b0;
      #1;
      n_checks++;
      if (op_count !== 16'hFFFF) begin n_fail++; $display("[TB] FAIL sat_count%0d: got %h want ffff", i, op_count); end
    end
  endtask
`endif

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    test_reset();
    test_basic_add();
    test_noop();
    test_back_to_back();
    test_error();
    test_hold_resp();
    test_reset_in_exec();
`ifdef ALU_ARB_FLAGS_EN
    test_flags_and_saturation();
`endif
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/alu_arbiter.md
Name: alu_arbiter

Overview:
- Shares one MIPSALU/ALUControl pair between two requesters, e.g. the execute stage (ID 0) and a branch-compare / address-gen unit (ID 1).
- Each requester uses valid/ready request and response handshakes.
- The arbiter picks round-robin, registers the operands, and drives the ALU for exactly one cycle.
- It captures result and flags into a response register, tagged with the requester ID, and counts completed operations.

Parameters:
- DATA_W, 32, operand/result width; must match the ALU (32).
- CNT_W, 16, width of the saturating completed-op counter.

Ports:
- clk  in  1  system clock; all state updates on the rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- req_valid  in  2  bit i: requester i presents an operation.
- req_ready  out  2  bit i: requester i's operation accepted this cycle; one-hot or zero.
- req_funct  in  12  {funct1, funct0}; 6-bit MIPS function codes.
- req_a  in  2*DATA_W  {a1, a0}.
- req_b  in  2*DATA_W  {b1, b0}.
- req_cin  in  2  carry-in per requester.
- alu_funct  out  6  to ALUControl alu_op.
- alu_a  out  DATA_W  to ALU a.
- alu_b  out  DATA_W  to ALU b.
- alu_cin  out  1  to ALU cin.
- alu_res  in  DATA_W  from ALU.
- alu_zero  in  1  ALU flag.
- alu_ovf  in  1  ALU flag.
- alu_cout  in  1  ALU flag.
- rsp_valid  out  1  response available.
- rsp_ready  in  1  consumer takes response.
- rsp_id  out  1  requester that issued the response.
- rsp_data  out  DATA_W  result.
- rsp_err  out  1  unsupported funct.
- op_count  out  CNT_W  completed responses; saturates at all-ones.

Behaviour:
- FSM states: IDLE, EXEC, RESP. Reset state is IDLE.
- Reset values: rsp_valid=0, rsp_id=0, rsp_data=0, rsp_err=0, op_count=0, operand registers=0, alu_funct=6'h2C (NOOP), last_grant=1 (so requester 0 wins the first tie).
- Reset mid-operation: the in-flight op is dropped, with no response.
- IDLE:
  - If any req_valid is set, grant one: a single requester wins outright; on a tie the requester != last_grant wins.
  - req_ready[g]=1 combinationally for that cycle only; funct/a/b/cin[g] latch, last_grant<=g, id<=g.
  - Valid funct codes: 20, 22, 24, 25, 26, 27, 2A, 2C.
  - Valid funct -> EXEC; any other funct -> RESP directly with rsp_err=1 and rsp_data=0.
  - req_ready is 0 in every other state.
- EXEC (exactly 1 cycle):
  - alu_funct/alu_a/alu_b/alu_cin are driven from the operand registers.
  - At the clock edge, rsp_data<=alu_res, rsp_err<=0; then go to RESP.
  - For funct 2C (NOOP) the ALU output is high-Z, so rsp_data is forced to 0 and rsp_err=0.
- Outside EXEC: alu_funct=6'h2C; alu_a/alu_b/alu_cin hold the operand registers.
- RESP:
  - rsp_valid=1; rsp_id/rsp_data/rsp_err stay stable until rsp_ready.
  - On rsp_valid&&rsp_ready: go to IDLE and increment op_count (no increment at all-ones).
  - New requests are not accepted in the handshake cycle.
- Latency: accept edge -> rsp_valid high 2 cycles later. Error ops: 1 cycle later. Peak throughput is 1 op per 3 cycles.
- req_valid may drop without a grant; no request is latched unless req_ready was high. Requesters hold inputs stable while valid and not ready.
- Simultaneous requests: grants alternate, so two continuously-valid requesters are served 0,1,0,1...

Optional Feature:
- Macro: ALU_ARB_FLAGS_EN.
- Defined:
  - Extra outputs rsp_zero, rsp_ovf, rsp_cout (1 bit each, reset 0) are captured from alu_zero/alu_ovf/alu_cout in EXEC.
  - These flags are forced to 0 for error ops and for NOOP.
- Undefined: the ports are absent and the alu_zero/alu_ovf/alu_cout inputs are unused.

Decomposition:
- Shared package/include (extends the existing ALU control include):
  - MIPS funct localparams (FUNCT_ADD=6'h20 ... FUNCT_NOOP=6'h2C).
  - ARB state encodings IDLE=2'd0, EXEC=2'd1, RESP=2'd2.
  - A funct-valid macro.
- One sub-module is natural: alu_rr_picker (combinational 2-way round-robin: req_valid, last_grant -> grant one-hot).

Test Plan:
- Reset release, then req0: funct 20, a=5, b=7, cin=0 -> req_ready[0] on that cycle; rsp_valid 2 cycles later with id=0, data=12, err=0; op_count=1 after rsp_ready.
- Both valid continuously: req0 funct 22 (a=10, b=3), req1 funct 2A (a=2, b=9) -> responses in order id0 data=7, id1 data=1, id0 data=7.
- req1 funct 6'h3F -> rsp 1 cycle after accept: id=1, err=1, data=0; the ALU never sees funct other than 2C.
- Hold rsp_ready=0 for 5 cycles during RESP while req0 is valid -> rsp fields stable, req_ready stays 0; accept happens only after the handshake plus 1 cycle.
- Assert rst_n=0 in EXEC -> all outputs return to reset values asynchronously; the op is lost; the next op is served normally.
- With ALU_ARB_FLAGS_EN: funct 20, a=32'h7FFFFFFF, b=1 -> data=32'h80000000, rsp_ovf=1, rsp_zero=0. With op_count preset near max by forcing, confirm saturation at 16'hFFFF.
